inst_fetch: RTL and testbench

//  Producer side of the instruction-word interface consumed by the decoder: owns the PC,

---
 rtl/rv32_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 50 +++++
 rtl/inst_fetch.sv | 105 ++++++++++
 tb/tb_inst_fetch.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 constants and the fetch-buffer entry type used by fetch and decode.
`default_nettype none
package rv32_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_WORD         = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] ir;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction
endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush and occupancy count; head reads as zero when empty.
`default_nettype none
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop   = pop & (count != '0);
  assign pop_data = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && count == (AW+1)'(DEPTH)));
endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
// inst_fetch: PC owner and instruction-memory requester feeding the decoder with ir/ir_pc.
// Credit-limited issue, in-order responses, redirect with drop of in-flight words, halt drain.
`default_nettype none
module inst_fetch
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] ir,
  output logic [XLEN-1:0] ir_pc,
  output logic            ir_valid,
  input  logic            ir_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted
);
  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic            halt_q;

  logic [CW-1:0]   buf_count;
  logic [CW-1:0]   tag_count;
  logic [XLEN-1:0] tag_head;
  fetch_entry_t    wr_entry;
  fetch_entry_t    rd_entry;

  logic issue, resp, drop_now, keep, consume;

  assign issue    = imem_req & imem_gnt;
  // A response with nothing outstanding is a straggler from before reset.
  assign resp     = imem_rvalid & (outstanding != '0);
  assign drop_now = resp & (drop_cnt != '0);
  assign keep     = resp & (drop_cnt == '0) & ~redirect;
  assign consume  = ir_valid & ir_ready;

  assign imem_req  = ~rst & ~halt_q & ~redirect &
                     (((CW+1)'(outstanding) + (CW+1)'(buf_count)) < CREDITS);
  assign imem_addr = pc;

  assign wr_entry = '{pc: tag_head, ir: imem_rdata};
  assign ir       = rd_entry.ir;
  assign ir_pc    = rd_entry.pc;
  assign ir_valid = (buf_count != '0);
  assign halted   = halt_q & (buf_count == '0) & (outstanding == '0);

  // Tag FIFO remembers the address of every kept request; drops never reach it
  // because it is flushed together with the word buffer on redirect.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data (pc),
    .pop       (keep),
    .flush     (redirect),
    .pop_data  (tag_head),
    .count     (tag_count)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (keep),
    .push_data (wr_entry),
    .pop       (consume),
    .flush     (redirect),
    .pop_data  (rd_entry),
    .count     (buf_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      halt_q      <= 1'b0;
    end else if (redirect) begin
      pc          <= align_word(redirect_pc);
      outstanding <= outstanding - CW'(resp);
      drop_cnt    <= outstanding - CW'(resp);
      halt_q      <= 1'b0;
    end else begin
      if (issue)    pc       <= pc + 32'd4;
      if (drop_now) drop_cnt <= drop_cnt - CW'(1);
      if (halt)     halt_q   <= 1'b1;
      outstanding <= outstanding + CW'(issue) - CW'(resp);
    end
  end

  a_tag_present: assert property (@(posedge clk) disable iff (rst)
    !(keep && tag_count == '0));
endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: table-driven streaming/backpressure vectors plus redirect, halt, wrap and reset sequences.
`default_nettype none
module tb_inst_fetch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        halted;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (gnt),
    .imem_rvalid (rvalid),
    .imem_rdata  (rdata),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .halted      (halted)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  // Memory model: fixed latency 1, one in-order response per cycle.
  typedef struct { logic [31:0] addr; int cyc; } pend_t;
  pend_t pend[$];
  int    cyc = 0;
  logic  resp_en = 1'b1;

  initial forever begin
    @(negedge clk);
    if (!rst && imem_req && gnt) pend.push_back('{addr: imem_addr, cyc: cyc});
    @(posedge clk);
    cyc++;
    #1;
    rvalid = 1'b0;
    if (resp_en && pend.size() > 0 && (cyc - pend[0].cyc) >= 1) begin
      rvalid = 1'b1;
      rdata  = word_of(pend[0].addr);
      void'(pend.pop_front());
    end
  end

  // Scoreboard: tests push expected pcs, every decoder handshake pops one.
  logic [31:0] exp_q[$];
  logic [31:0] sb_e;
  initial forever begin
    @(negedge clk);
    if (!rst && ir_valid && ir_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got ir_pc %h expected no word", ir_pc);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_pc", ir_pc, sb_e);
        chk("sb_ir", ir, word_of(sb_e));
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; gnt = 1'b0; halt = 1'b0; redirect = 1'b0;
    ir_ready = 1'b1; resp_en = 1'b1;
    pend.delete();
    exp_q.delete();
    next();
    next();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t tbl[15];

  bit found;

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
    tbl[1]  = '{1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
    tbl[2]  = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd0};
    tbl[3]  = '{1'b1, 1'b1, 32'd12, 1'b1, 32'd4};
    tbl[4]  = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd8};
    tbl[5]  = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd12};
    tbl[6]  = '{1'b0, 1'b1, 32'd24, 1'b1, 32'd16};
    tbl[7]  = '{1'b0, 1'b1, 32'd28, 1'b1, 32'd16};
    tbl[8]  = '{1'b0, 1'b0, 32'd32, 1'b1, 32'd16};
    tbl[9]  = '{1'b0, 1'b0, 32'd32, 1'b1, 32'd16};
    tbl[10] = '{1'b0, 1'b0, 32'd32, 1'b1, 32'd16};
    tbl[11] = '{1'b1, 1'b0, 32'd32, 1'b1, 32'd16};
    tbl[12] = '{1'b1, 1'b1, 32'd32, 1'b1, 32'd20};
    tbl[13] = '{1'b1, 1'b1, 32'd36, 1'b1, 32'd24};
    tbl[14] = '{1'b1, 1'b1, 32'd40, 1'b1, 32'd28};

    // Reset state
    next();
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_ir_pc", ir_pc, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);

    // Streaming, then backpressure filling the buffer
    do_reset();
    gnt = 1'b1;
    for (int p = 0; p <= 28; p += 4) exp_q.push_back(32'(p));
    for (int i = 0; i < 15; i++) begin
      ir_ready = tbl[i].ready;
      @(negedge clk);
      chk($sformatf("tbl%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].exp_req});
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_valid", i), {31'd0, ir_valid}, {31'd0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_pc", i), ir_pc, tbl[i].exp_pc);
        chk($sformatf("tbl%0d_ir", i), ir, word_of(tbl[i].exp_pc));
      end
      next();
    end
    rst = 1'b1;
    chk("tbl_sb_drained", exp_q.size(), 32'd0);

    // Redirect with two words in flight
    do_reset();
    resp_en = 1'b0;
    gnt = 1'b1;
    next();
    next();
    gnt = 1'b0;
    next();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    chk("redir_req_off", {31'd0, imem_req}, 32'd0);
    next();
    redirect = 1'b0;
    resp_en = 1'b1;
    gnt = 1'b1;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    @(negedge clk);
    chk("redir_req_on", {31'd0, imem_req}, 32'd1);
    chk("redir_addr0", imem_addr, 32'h100);
    next();
    @(negedge clk);
    chk("redir_addr1", imem_addr, 32'h104);
    next();
    gnt = 1'b0;
    repeat (8) next();
    chk("redir_sb_drained", exp_q.size(), 32'd0);
    chk("redir_idle", {31'd0, ir_valid}, 32'd0);

    // Halt at ir_pc 0x10: in-flight words still delivered
    do_reset();
    gnt = 1'b1;
    for (int p = 0; p <= 24; p += 4) exp_q.push_back(32'(p));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (ir_valid && ir_pc == 32'h10) found = 1'b1;
      else next();
    end
    chk("halt_found", {31'd0, found}, 32'd1);
    halt = 1'b1;
    next();
    halt = 1'b0;
    @(negedge clk);
    chk("halt_req_off", {31'd0, imem_req}, 32'd0);
    chk("halt_not_yet0", {31'd0, halted}, 32'd0);
    next();
    @(negedge clk);
    chk("halt_not_yet1", {31'd0, halted}, 32'd0);
    chk("halt_last_pc", ir_pc, 32'h18);
    next();
    @(negedge clk);
    chk("halted", {31'd0, halted}, 32'd1);
    chk("halt_empty", {31'd0, ir_valid}, 32'd0);
    next();
    @(negedge clk);
    chk("halted_sticky", {31'd0, halted}, 32'd1);
    chk("halt_req_still_off", {31'd0, imem_req}, 32'd0);
    chk("halt_sb_drained", exp_q.size(), 32'd0);

    // Redirect to the top word (with halt in the same cycle), then wrap
    do_reset();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    halt = 1'b1;
    @(negedge clk);
    chk("wrap_redir_req_off", {31'd0, imem_req}, 32'd0);
    next();
    redirect = 1'b0;
    halt = 1'b0;
    gnt = 1'b1;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    @(negedge clk);
    chk("wrap_req_on", {31'd0, imem_req}, 32'd1);
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    next();
    @(negedge clk);
    chk("wrap_addr_zero", imem_addr, 32'h0);
    next();
    gnt = 1'b0;
    repeat (6) next();
    chk("wrap_sb_drained", exp_q.size(), 32'd0);

    // Reset with two outstanding; late responses must be ignored
    do_reset();
    resp_en = 1'b0;
    gnt = 1'b1;
    next();
    next();
    gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_req", {31'd0, imem_req}, 32'd0);
    chk("rst2_valid", {31'd0, ir_valid}, 32'd0);
    next();
    rst = 1'b0;
    resp_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("stale%0d_valid", i), {31'd0, ir_valid}, 32'd0);
      chk($sformatf("stale%0d_addr", i), imem_addr, 32'd0);
      chk($sformatf("stale%0d_req", i), {31'd0, imem_req}, 32'd1);
      next();
    end
    gnt = 1'b1;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    next();
    next();
    gnt = 1'b0;
    repeat (6) next();
    chk("rst2_sb_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
